// File: rtl/pong_match_ctrl_pkg.sv
// Shared types and defaults for the ping-pong match controller.
package pong_match_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SERVE_WAIT = 3'd1,
    RALLY      = 3'd2,
    POINT_HOLD = 3'd3,
    MATCH_END  = 3'd4
  } state_t;

  localparam logic SIDE_R = 1'b0;
  localparam logic SIDE_L = 1'b1;

  localparam int unsigned SPEED_W = 2;
  localparam int unsigned SCORE_W = 4;

  localparam int unsigned DEF_WIN_POINTS      = 11;
  localparam int unsigned DEF_SERVES_PER_TURN = 2;
  localparam int unsigned DEF_HITS_PER_LEVEL  = 4;
  localparam int unsigned DEF_HOLD_TICKS      = 8;

endpackage

// File: rtl/pong_match_ctrl_rise_det.sv
// Rising-edge detector: registered previous level, one-cycle rise strobe.
module pong_match_ctrl_rise_det (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise_c
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (!rst) prev_q <= 1'b0;
    else      prev_q <= level;
  end

  assign rise_c = level & ~prev_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer: serve gating, scoring with win-by-2, serve rotation,
// rally-length speed scheduling and score display hold.
module pong_match_ctrl
  import pong_match_ctrl_pkg::*;
#(
  parameter int unsigned WIN_POINTS      = DEF_WIN_POINTS,
  parameter int unsigned SERVES_PER_TURN = DEF_SERVES_PER_TURN,
  parameter int unsigned HITS_PER_LEVEL  = DEF_HITS_PER_LEVEL,
  parameter int unsigned HOLD_TICKS      = DEF_HOLD_TICKS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       click_R,
  input  logic       click_L,
  input  logic       rally_hit,
  input  logic       point_R,
  input  logic       point_L,
  output logic       serve_en,
  output logic       serve_side,
  output logic [1:0] speed_sel,
  output logic [3:0] score_R,
  output logic [3:0] score_L,
  output logic       show_score,
  output logic       match_over,
  output logic       winner
);

  localparam int unsigned HIT_W  = 5;
  localparam int unsigned HOLD_W = 4;
  localparam int unsigned SRV_W  = 2;

  state_t               state_q, state_d;
  logic [HIT_W-1:0]     hits_q, hits_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [SRV_W-1:0]     srv_q, srv_d, srv_n;
  logic [SCORE_W-1:0]   score_r_d, score_l_d;
  logic                 side_d, winner_d;
  logic [SPEED_W-1:0]   speed_d;
  logic                 rise_r, rise_l, r_win, l_win, deuce, serve_rise;

  pong_match_ctrl_rise_det u_rise_r (.clk(clk), .rst(rst), .level(click_R), .rise_c(rise_r));
  pong_match_ctrl_rise_det u_rise_l (.clk(clk), .rst(rst), .level(click_L), .rise_c(rise_l));

  // Match decision and deuce use the scores as they stand during the hold.
  assign r_win = ({1'b0, score_R} >= 5'(WIN_POINTS)) && ({1'b0, score_R} >= {1'b0, score_L} + 5'd2);
  assign l_win = ({1'b0, score_L} >= 5'(WIN_POINTS)) && ({1'b0, score_L} >= {1'b0, score_R} + 5'd2);
  assign deuce = (score_R >= 4'(WIN_POINTS - 1)) && (score_L >= 4'(WIN_POINTS - 1));
  assign srv_n = srv_q + 2'd1;
  assign serve_rise = (serve_side == SIDE_L) ? rise_l : rise_r;

  always_comb begin
    state_d   = state_q;
    hits_d    = hits_q;
    hold_d    = hold_q;
    srv_d     = srv_q;
    score_r_d = score_R;
    score_l_d = score_L;
    side_d    = serve_side;
    winner_d  = winner;

    unique case (state_q)
      IDLE: begin
        if (rise_r || rise_l) begin
          state_d = SERVE_WAIT;
          side_d  = SIDE_R;
        end
      end
      SERVE_WAIT: begin
        if (serve_rise) state_d = RALLY;
      end
      RALLY: begin
        if (rally_hit && (hits_q != '1)) hits_d = hits_q + 5'd1;
        if (point_R ^ point_L) begin
          if (point_R && (score_R != '1)) score_r_d = score_R + 4'd1;
          if (point_L && (score_L != '1)) score_l_d = score_L + 4'd1;
          hold_d  = '0;
          state_d = POINT_HOLD;
        end else if (point_R && point_L) begin
          hits_d  = '0;
          state_d = SERVE_WAIT;
        end
      end
      POINT_HOLD: begin
        if (tick) begin
          if (hold_q == 4'(HOLD_TICKS - 1)) begin
            hold_d = '0;
            if (r_win || l_win) begin
              winner_d = l_win;
              state_d  = MATCH_END;
            end else begin
              if ((srv_n == 2'(SERVES_PER_TURN)) || deuce) begin
                side_d = ~serve_side;
                srv_d  = '0;
              end else begin
                srv_d  = srv_n;
              end
              hits_d  = '0;
              state_d = SERVE_WAIT;
            end
          end else begin
            hold_d = hold_q + 4'd1;
          end
        end
      end
      MATCH_END: begin
        if (click_R && click_L) begin
          score_r_d = '0;
          score_l_d = '0;
          hits_d    = '0;
          hold_d    = '0;
          srv_d     = '0;
          winner_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Speed level follows the post-edge hit count.
    speed_d = 2'd0;
    if      (hits_d >= 5'(3 * HITS_PER_LEVEL)) speed_d = 2'd3;
    else if (hits_d >= 5'(2 * HITS_PER_LEVEL)) speed_d = 2'd2;
    else if (hits_d >= 5'(HITS_PER_LEVEL))     speed_d = 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      hits_q     <= '0;
      hold_q     <= '0;
      srv_q      <= '0;
      score_R    <= '0;
      score_L    <= '0;
      serve_side <= SIDE_R;
      winner     <= 1'b0;
      serve_en   <= 1'b0;
      speed_sel  <= '0;
      show_score <= 1'b0;
      match_over <= 1'b0;
    end else begin
      state_q    <= state_d;
      hits_q     <= hits_d;
      hold_q     <= hold_d;
      srv_q      <= srv_d;
      score_R    <= score_r_d;
      score_L    <= score_l_d;
      serve_side <= side_d;
      winner     <= winner_d;
      serve_en   <= (state_d == SERVE_WAIT);
      speed_sel  <= speed_d;
      show_score <= (state_d == IDLE) || (state_d == POINT_HOLD) || (state_d == MATCH_END);
      match_over <= (state_d == MATCH_END);
    end
  end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl against a point-level match model.
module tb_pong_match_ctrl;

  localparam int WIN  = 11;
  localparam int SPT  = 2;
  localparam int HPL  = 4;
  localparam int HOLD = 8;

  logic       clk = 1'b0, rst = 1'b0, tick = 1'b0;
  logic       click_R = 1'b0, click_L = 1'b0, rally_hit = 1'b0;
  logic       point_R = 1'b0, point_L = 1'b0;
  logic       serve_en, serve_side, show_score, match_over, winner;
  logic [1:0] speed_sel;
  logic [3:0] score_R, score_L;

  int n_cmp = 0, n_bad = 0;

  // Match model: scores, serve counter, server, outcome.
  int   m_r, m_l, m_srv;
  logic m_side, m_over, m_win;

  pong_match_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .click_R(click_R), .click_L(click_L),
    .rally_hit(rally_hit), .point_R(point_R), .point_L(point_L),
    .serve_en(serve_en), .serve_side(serve_side), .speed_sel(speed_sel),
    .score_R(score_R), .score_L(score_L), .show_score(show_score),
    .match_over(match_over), .winner(winner)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] exp_speed(int h);
    int e;
    e = h / HPL;
    if (e > 3) e = 3;
    return 2'(e);
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic model_clear();
    m_r = 0; m_l = 0; m_srv = 0; m_side = 1'b0; m_over = 1'b0; m_win = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; step(); rst = 1'b1; step();
    model_clear();
  endtask

  task automatic press(input logic side);
    if (side) click_L = 1'b1; else click_R = 1'b1;
    step();
    click_L = 1'b0; click_R = 1'b0;
    step();
  endtask

  task automatic hits(input int n);
    repeat (n) begin
      rally_hit = 1'b1; step(); rally_hit = 1'b0;
      if ($urandom_range(0, 1) == 1) step();
    end
  endtask

  task automatic start_match();
    press(1'($urandom_range(0, 1)));
    m_side = 1'b0; m_srv = 0;
  endtask

  task automatic score_point(input logic w);
    if (w) point_L = 1'b1; else point_R = 1'b1;
    step();
    point_L = 1'b0; point_R = 1'b0;
    if (w) begin if (m_l < 15) m_l++; end
    else   begin if (m_r < 15) m_r++; end
  endtask

  task automatic rally_point(input logic w, input int h);
    press(m_side);
    hits(h);
    score_point(w);
  endtask

  task automatic model_after_hold();
    if ((m_r >= WIN && m_r >= m_l + 2) || (m_l >= WIN && m_l >= m_r + 2)) begin
      m_over = 1'b1;
      m_win  = (m_l > m_r);
    end else begin
      m_srv++;
      if (m_srv == SPT || (m_r >= WIN - 1 && m_l >= WIN - 1)) begin
        m_side = ~m_side;
        m_srv  = 0;
      end
    end
  endtask

  task automatic run_hold();
    repeat (HOLD) begin
      repeat ($urandom_range(0, 2)) step();
      tick = 1'b1; step(); tick = 1'b0;
    end
    step();
    model_after_hold();
  endtask

  task automatic test_reset();
    int nr, nl;
    do_reset();
    start_match();
    nr = 0; nl = 0;
    while (nr < 3 || nl < 2) begin
      if (nl >= 2 || (nr < 3 && $urandom_range(0, 1) == 0)) begin
        rally_point(1'b0, $urandom_range(0, 6)); nr++;
      end else begin
        rally_point(1'b1, $urandom_range(0, 6)); nl++;
      end
      run_hold();
    end
    press(m_side);
    hits(9);
    n_cmp++; if (score_R !== 4'd3 || score_L !== 4'd2) begin n_bad++;
      $display("FAIL pre_reset_score got=%0d-%0d exp=3-2", score_R, score_L); end
    n_cmp++; if (speed_sel !== 2'd2) begin n_bad++;
      $display("FAIL pre_reset_speed got=%0d exp=2", speed_sel); end
    rst = 1'b0; step();
    n_cmp++; if ({serve_en, serve_side, speed_sel, score_R, score_L, show_score, match_over, winner} !== 15'd0) begin n_bad++;
      $display("FAIL reset_outputs got en=%0b side=%0b spd=%0d sc=%0d-%0d show=%0b over=%0b win=%0b exp all 0",
               serve_en, serve_side, speed_sel, score_R, score_L, show_score, match_over, winner); end
    rst = 1'b1; step();
    model_clear();
    n_cmp++; if (show_score !== 1'b1 || serve_en !== 1'b0 || score_R !== 4'd0) begin n_bad++;
      $display("FAIL idle_after_reset got show=%0b en=%0b scR=%0d exp show=1 en=0 scR=0", show_score, serve_en, score_R); end
  endtask

  task automatic test_serve_speed();
    do_reset();
    press(1'b1);
    n_cmp++; if (serve_en !== 1'b1 || serve_side !== 1'b0 || speed_sel !== 2'd0 || show_score !== 1'b0) begin n_bad++;
      $display("FAIL serve_wait_entry got en=%0b side=%0b spd=%0d show=%0b exp 1 0 0 0", serve_en, serve_side, speed_sel, show_score); end
    press(1'b1);
    n_cmp++; if (serve_en !== 1'b1) begin n_bad++;
      $display("FAIL other_click_ignored got en=%0b exp=1", serve_en); end
    press(1'b0);
    n_cmp++; if (serve_en !== 1'b0 || show_score !== 1'b0) begin n_bad++;
      $display("FAIL rally_entry got en=%0b show=%0b exp 0 0", serve_en, show_score); end
    for (int i = 1; i <= 20; i++) begin
      rally_hit = 1'b1; step(); rally_hit = 1'b0;
      n_cmp++; if (speed_sel !== exp_speed(i)) begin n_bad++;
        $display("FAIL speed_after_%0d_hits got=%0d exp=%0d", i, speed_sel, exp_speed(i)); end
    end
  endtask

  task automatic test_rotation();
    do_reset();
    start_match();
    rally_point(1'b0, 2);
    n_cmp++; if (score_R !== 4'd1 || score_L !== 4'd0 || show_score !== 1'b1 || serve_en !== 1'b0) begin n_bad++;
      $display("FAIL first_point got sc=%0d-%0d show=%0b en=%0b exp 1-0 1 0", score_R, score_L, show_score, serve_en); end
    repeat (HOLD - 1) begin tick = 1'b1; step(); tick = 1'b0; step(); end
    n_cmp++; if (serve_en !== 1'b0 || show_score !== 1'b1) begin n_bad++;
      $display("FAIL hold_not_done got en=%0b show=%0b exp 0 1", serve_en, show_score); end
    tick = 1'b1; step(); tick = 1'b0;
    model_after_hold();
    n_cmp++; if (serve_en !== 1'b1 || serve_side !== m_side || speed_sel !== 2'd0 || show_score !== 1'b0) begin n_bad++;
      $display("FAIL after_hold1 got en=%0b side=%0b spd=%0d show=%0b exp 1 %0b 0 0", serve_en, serve_side, speed_sel, show_score, m_side); end
    rally_point(1'b0, 5);
    run_hold();
    n_cmp++; if (serve_side !== m_side || score_R !== 4'd2) begin n_bad++;
      $display("FAIL after_hold2 got side=%0b scR=%0d exp side=%0b scR=2", serve_side, score_R, m_side); end
  endtask

  task automatic test_deuce_win();
    do_reset();
    start_match();
    for (int i = 0; i < 10; i++) begin
      rally_point(1'b0, $urandom_range(0, 3)); run_hold();
      rally_point(1'b1, $urandom_range(0, 3)); run_hold();
    end
    n_cmp++; if (score_R !== 4'd10 || score_L !== 4'd10 || serve_side !== m_side) begin n_bad++;
      $display("FAIL deuce_10_10 got sc=%0d-%0d side=%0b exp 10-10 side=%0b", score_R, score_L, serve_side, m_side); end
    rally_point(1'b1, 1);
    run_hold();
    n_cmp++; if (score_L !== 4'd11 || match_over !== 1'b0 || serve_side !== m_side || serve_en !== 1'b1) begin n_bad++;
      $display("FAIL adv_10_11 got scL=%0d over=%0b side=%0b en=%0b exp 11 0 %0b 1", score_L, match_over, serve_side, serve_en, m_side); end
    rally_point(1'b1, 1);
    n_cmp++; if (score_L !== 4'd12 || match_over !== 1'b0) begin n_bad++;
      $display("FAIL win_before_hold got scL=%0d over=%0b exp 12 0", score_L, match_over); end
    run_hold();
    n_cmp++; if (match_over !== 1'b1 || winner !== 1'b1 || show_score !== 1'b1 || serve_en !== 1'b0) begin n_bad++;
      $display("FAIL match_won got over=%0b win=%0b show=%0b en=%0b exp 1 1 1 0", match_over, winner, show_score, serve_en); end
  endtask

  task automatic test_match_end();
    click_R = 1'b1;
    repeat (4) step();
    n_cmp++; if (match_over !== 1'b1 || score_L !== 4'd12) begin n_bad++;
      $display("FAIL right_held_stays got over=%0b scL=%0d exp 1 12", match_over, score_L); end
    click_L = 1'b1; step();
    click_R = 1'b0; click_L = 1'b0; step();
    model_clear();
    n_cmp++; if (match_over !== 1'b0 || score_R !== 4'd0 || score_L !== 4'd0 || show_score !== 1'b1 || serve_en !== 1'b0) begin n_bad++;
      $display("FAIL match_cleared got over=%0b sc=%0d-%0d show=%0b en=%0b exp 0 0-0 1 0", match_over, score_R, score_L, show_score, serve_en); end
    click_R = 1'b1; click_L = 1'b1; step();
    click_R = 1'b0; click_L = 1'b0; step();
    n_cmp++; if (serve_en !== 1'b1 || serve_side !== 1'b0) begin n_bad++;
      $display("FAIL idle_both_rise got en=%0b side=%0b exp 1 0", serve_en, serve_side); end
  endtask

  task automatic test_let_ignore();
    do_reset();
    start_match();
    rally_point(1'b0, 3);
    run_hold();
    press(m_side);
    hits(6);
    point_R = 1'b1; point_L = 1'b1; step(); point_R = 1'b0; point_L = 1'b0;
    n_cmp++; if (score_R !== 4'd1 || score_L !== 4'd0 || serve_en !== 1'b1 || serve_side !== m_side || speed_sel !== 2'd0) begin n_bad++;
      $display("FAIL let got sc=%0d-%0d en=%0b side=%0b spd=%0d exp 1-0 1 %0b 0", score_R, score_L, serve_en, serve_side, speed_sel, m_side); end
    point_R = 1'b1; step(); point_R = 1'b0; step();
    n_cmp++; if (score_R !== 4'd1 || serve_en !== 1'b1) begin n_bad++;
      $display("FAIL point_in_serve_wait got scR=%0d en=%0b exp 1 1", score_R, serve_en); end
    rally_point(1'b1, 2);
    point_R = 1'b1; step(); point_R = 1'b0;
    n_cmp++; if (score_R !== 4'd1 || score_L !== 4'd1) begin n_bad++;
      $display("FAIL point_in_hold got sc=%0d-%0d exp 1-1", score_R, score_L); end
    run_hold();
    n_cmp++; if (serve_side !== m_side || serve_en !== 1'b1) begin n_bad++;
      $display("FAIL let_serve_count got side=%0b en=%0b exp %0b 1", serve_side, serve_en, m_side); end
  endtask

  task automatic test_random();
    int h;
    logic w;
    for (int m = 0; m < 3; m++) begin
      do_reset();
      start_match();
      for (int p = 0; p < 80 && !m_over; p++) begin
        if ($urandom_range(0, 3) == 0) begin
          press(~m_side);
          n_cmp++; if (serve_en !== 1'b1) begin n_bad++;
            $display("FAIL rnd_wrong_side_serve got en=%0b exp=1", serve_en); end
        end
        h = $urandom_range(0, 14);
        w = 1'($urandom_range(0, 1));
        press(m_side);
        hits(h);
        n_cmp++; if (speed_sel !== exp_speed(h)) begin n_bad++;
          $display("FAIL rnd_speed hits=%0d got=%0d exp=%0d", h, speed_sel, exp_speed(h)); end
        score_point(w);
        n_cmp++; if (score_R !== 4'(m_r) || score_L !== 4'(m_l)) begin n_bad++;
          $display("FAIL rnd_score got=%0d-%0d exp=%0d-%0d", score_R, score_L, m_r, m_l); end
        run_hold();
        n_cmp++; if (match_over !== m_over || serve_en !== ~m_over || (!m_over && serve_side !== m_side)) begin n_bad++;
          $display("FAIL rnd_after_hold got over=%0b en=%0b side=%0b exp over=%0b side=%0b", match_over, serve_en, serve_side, m_over, m_side); end
      end
      if (m_over) begin
        n_cmp++; if (winner !== m_win) begin n_bad++;
          $display("FAIL rnd_winner got=%0b exp=%0b", winner, m_win); end
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_serve_speed();
    test_rotation();
    test_deuce_win();
    test_match_end();
    test_let_ignore();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    n_bad++;
    $display("FAIL watchdog timeout got=running exp=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
